// File: rtl/decode_scoreboard_pkg.sv
// Shared constants, enable-bit positions and FSM encoding for the decode scoreboard.
// Latency: n/a. Backpressure: n/a.
package decode_scoreboard_pkg;

    localparam int NUM_RF        = 16;
    localparam int NUM_VRF       = 64;
    localparam int VREG_ID_WIDTH = $clog2(NUM_VRF);
    localparam int RF_IDX_WIDTH  = 4;
    localparam int CNT_WIDTH     = 2;

    // {CC,V,S} positions in I_DestWrite / I_WBEn
    localparam int WB_S  = 0;
    localparam int WB_V  = 1;
    localparam int WB_CC = 2;

    // {CC,V2,V1,S2,S1} positions in I_SrcUse
    localparam int SRC_S1 = 0;
    localparam int SRC_S2 = 1;
    localparam int SRC_V1 = 2;
    localparam int SRC_V2 = 3;
    localparam int SRC_CC = 4;

    typedef enum logic {
        SCBD_IDLE    = 1'b0,
        SCBD_BR_WAIT = 1'b1
    } scbd_state_e;

endpackage

// File: rtl/decode_scoreboard_pending_counter.sv
// Saturating pending-write counter for one register; flags overflow/underflow.
// Latency: count updates on the clock edge; pend_o is combinational on the current count.
// Backpressure: none; en_i low freezes the count. SCBD_BYPASS_EN releases pend_o on the last writeback.
module decode_scoreboard_pending_counter
    import decode_scoreboard_pkg::*;
#(
    parameter int CNT_W = CNT_WIDTH
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic pend_o,
    output logic err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        err_o = 1'b0;
        if (en_i) begin
            case ({inc_i, dec_i})
                2'b10: begin
                    if (cnt_q == CNT_MAX) err_o = 1'b1;
                    else                  cnt_d = cnt_q + CNT_ONE;
                end
                2'b01: begin
                    if (cnt_q == '0) err_o = 1'b1;
                    else             cnt_d = cnt_q - CNT_ONE;
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

`ifdef SCBD_BYPASS_EN
    // RF is written in the first half-cycle, so the final writeback already satisfies a reader.
    assign pend_o = (cnt_q != '0) & ~((cnt_q == CNT_ONE) & dec_i);
`else
    assign pend_o = (cnt_q != '0);
`endif

endmodule

// File: rtl/decode_scoreboard.sv
// Decode hazard/issue controller: pending-write counters per RF/VRF/CC register, dep and branch stalls.
// Latency: issue and stalls are combinational (0 cycles); stall release 1 cycle after the clearing writeback edge.
// Backpressure: I_GPUStallSignal / I_LOCK=0 block issue; SCBD_BYPASS_EN enables same-cycle writeback release.
module decode_scoreboard
    import decode_scoreboard_pkg::*;
(
    input  logic                     I_CLOCK,
    input  logic                     I_RESET_N,
    input  logic                     I_LOCK,
    input  logic                     I_FE_Valid,
    input  logic [3:0]               I_Src1Idx,
    input  logic [3:0]               I_Src2Idx,
    input  logic [VREG_ID_WIDTH-1:0] I_VSrc1Idx,
    input  logic [VREG_ID_WIDTH-1:0] I_VSrc2Idx,
    input  logic [4:0]               I_SrcUse,
    input  logic                     I_IsCtrl,
    input  logic [3:0]               I_DestIdx,
    input  logic [VREG_ID_WIDTH-1:0] I_VDestIdx,
    input  logic [2:0]               I_DestWrite,
    input  logic                     I_GPUStallSignal,
    input  logic [3:0]               I_WriteBackRegIdx,
    input  logic [VREG_ID_WIDTH-1:0] I_WriteBackVRegIdx,
    input  logic [2:0]               I_WBEn,
    input  logic                     I_WriteBackPCEn,
    output logic                     O_DepStallSignal,
    output logic                     O_BranchStallSignal,
    output logic                     O_Issue,
    output logic                     O_Error
);

    scbd_state_e        state_q, state_d;
    logic               err_q, err_d;
    logic               dep;
    logic               issue;
    logic               dep_stall;
    logic               branch_stall;

    logic [NUM_RF-1:0]  pend_rf, err_rf;
    logic [NUM_VRF-1:0] pend_vrf, err_vrf;
    logic               pend_cc, err_cc;

    for (genvar i = 0; i < NUM_RF; i++) begin : g_rf
        decode_scoreboard_pending_counter u_cnt (
            .clk_i  (I_CLOCK),
            .rst_ni (I_RESET_N),
            .en_i   (I_LOCK),
            .inc_i  (issue & I_DestWrite[WB_S] & (I_DestIdx == RF_IDX_WIDTH'(i))),
            .dec_i  (I_WBEn[WB_S] & (I_WriteBackRegIdx == RF_IDX_WIDTH'(i))),
            .pend_o (pend_rf[i]),
            .err_o  (err_rf[i])
        );
    end

    for (genvar i = 0; i < NUM_VRF; i++) begin : g_vrf
        decode_scoreboard_pending_counter u_cnt (
            .clk_i  (I_CLOCK),
            .rst_ni (I_RESET_N),
            .en_i   (I_LOCK),
            .inc_i  (issue & I_DestWrite[WB_V] & (I_VDestIdx == VREG_ID_WIDTH'(i))),
            .dec_i  (I_WBEn[WB_V] & (I_WriteBackVRegIdx == VREG_ID_WIDTH'(i))),
            .pend_o (pend_vrf[i]),
            .err_o  (err_vrf[i])
        );
    end

    decode_scoreboard_pending_counter u_cnt_cc (
        .clk_i  (I_CLOCK),
        .rst_ni (I_RESET_N),
        .en_i   (I_LOCK),
        .inc_i  (issue & I_DestWrite[WB_CC]),
        .dec_i  (I_WBEn[WB_CC]),
        .pend_o (pend_cc),
        .err_o  (err_cc)
    );

    assign dep = I_FE_Valid & ((I_SrcUse[SRC_S1] & pend_rf[I_Src1Idx])   |
                               (I_SrcUse[SRC_S2] & pend_rf[I_Src2Idx])   |
                               (I_SrcUse[SRC_V1] & pend_vrf[I_VSrc1Idx]) |
                               (I_SrcUse[SRC_V2] & pend_vrf[I_VSrc2Idx]) |
                               (I_SrcUse[SRC_CC] & pend_cc));

    // Outputs are forced low while reset is asserted, even with a valid instruction presented.
    always_comb begin
        state_d      = state_q;
        issue        = 1'b0;
        dep_stall    = 1'b0;
        branch_stall = 1'b0;
        if (I_RESET_N & I_LOCK) begin
            case (state_q)
                SCBD_IDLE: begin
                    dep_stall    = dep;
                    issue        = I_FE_Valid & ~dep & ~I_GPUStallSignal;
                    branch_stall = I_FE_Valid & I_IsCtrl;
                    if (issue & I_IsCtrl) state_d = SCBD_BR_WAIT;
                end
                SCBD_BR_WAIT: begin
                    branch_stall = 1'b1;
                    if (I_WriteBackPCEn) state_d = SCBD_IDLE;
                end
                default: state_d = SCBD_IDLE;
            endcase
        end
    end

    assign err_d = err_q | (|err_rf) | (|err_vrf) | err_cc;

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q <= SCBD_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign O_DepStallSignal    = dep_stall;
    assign O_BranchStallSignal = branch_stall;
    assign O_Issue             = issue;
    assign O_Error             = err_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Randomized + directed bench for decode_scoreboard against a per-register count model.
module tb_decode_scoreboard;

`ifdef SCBD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int MAXC = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lock, fe, isctrl, gpu, pcen;
    logic [3:0] src1, src2, dest, wbidx;
    logic [5:0] vsrc1, vsrc2, vdest, wbvidx;
    logic [4:0] use_;
    logic [2:0] dw, wben;
    logic       dstall, bstall, issue, err;

    int  m_s[16];
    int  m_v[64];
    int  m_cc;
    bit  m_bw, m_err;
    int  pass_cnt = 0, total_cnt = 0, cyc_n = 0;
    logic got_dep, got_bs, got_iss, got_err;

    always #5 clk = ~clk;

    decode_scoreboard dut (
        .I_CLOCK(clk), .I_RESET_N(rst_n), .I_LOCK(lock), .I_FE_Valid(fe),
        .I_Src1Idx(src1), .I_Src2Idx(src2), .I_VSrc1Idx(vsrc1), .I_VSrc2Idx(vsrc2),
        .I_SrcUse(use_), .I_IsCtrl(isctrl), .I_DestIdx(dest), .I_VDestIdx(vdest),
        .I_DestWrite(dw), .I_GPUStallSignal(gpu), .I_WriteBackRegIdx(wbidx),
        .I_WriteBackVRegIdx(wbvidx), .I_WBEn(wben), .I_WriteBackPCEn(pcen),
        .O_DepStallSignal(dstall), .O_BranchStallSignal(bstall), .O_Issue(issue), .O_Error(err)
    );

    task automatic check(input string name, input logic got, input logic exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc_n, got, exp);
    endtask

    // A register blocks a reader while writes are outstanding; with bypass, the last outstanding
    // write being written back this cycle no longer blocks.
    function automatic bit pending(input int c, input bit wb_hit);
        return (c != 0) && !(BYP && c == 1 && wb_hit);
    endfunction

    function automatic bit model_dep();
        bit d;
        d = (use_[0] && pending(m_s[src1],  wben[0] && wbidx  == src1))  ||
            (use_[1] && pending(m_s[src2],  wben[0] && wbidx  == src2))  ||
            (use_[2] && pending(m_v[vsrc1], wben[1] && wbvidx == vsrc1)) ||
            (use_[3] && pending(m_v[vsrc2], wben[1] && wbvidx == vsrc2)) ||
            (use_[4] && pending(m_cc,       wben[2]));
        return fe && d;
    endfunction

    function automatic int upd(input int c, input int d);
        if (d > 0 && c == MAXC) begin m_err = 1'b1; return c; end
        if (d < 0 && c == 0)    begin m_err = 1'b1; return c; end
        return c + d;
    endfunction

    task automatic model_update(input bit e_iss);
        if (!(rst_n && lock)) return;
        for (int i = 0; i < 16; i++)
            m_s[i] = upd(m_s[i], int'(e_iss && dw[0] && dest == i) - int'(wben[0] && wbidx == i));
        for (int i = 0; i < 64; i++)
            m_v[i] = upd(m_v[i], int'(e_iss && dw[1] && vdest == i) - int'(wben[1] && wbvidx == i));
        m_cc = upd(m_cc, int'(e_iss && dw[2]) - int'(wben[2]));
        if (!m_bw) begin
            if (e_iss && isctrl) m_bw = 1'b1;
        end else if (pcen) begin
            m_bw = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_s[i] = 0;
        for (int i = 0; i < 64; i++) m_v[i] = 0;
        m_cc = 0; m_bw = 1'b0; m_err = 1'b0;
    endtask

    // Inputs are held from just after one posedge to just after the next.
    task automatic cyc();
        bit e_dep, e_iss, act;
        @(negedge clk);
        act   = rst_n && lock;
        e_dep = model_dep();
        e_iss = act && fe && !m_bw && !e_dep && !gpu;
        check("dep_stall",    dstall, act && !m_bw && e_dep);
        check("issue",        issue,  e_iss);
        check("branch_stall", bstall, act && (m_bw || (fe && isctrl)));
        check("error",        err,    m_err);
        got_dep = dstall; got_iss = issue; got_bs = bstall; got_err = err;
        @(posedge clk);
        model_update(e_iss);
        #1;
        cyc_n++;
    endtask

    task automatic idle();
        lock = 1'b1; fe = 1'b0; isctrl = 1'b0; gpu = 1'b0; pcen = 1'b0;
        src1 = '0; src2 = '0; dest = '0; wbidx = '0;
        vsrc1 = '0; vsrc2 = '0; vdest = '0; wbvidx = '0;
        use_ = '0; dw = '0; wben = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_dep",   dstall, 1'b0);
        check("rst_issue", issue,  1'b0);
        check("rst_bs",    bstall, 1'b0);
        check("rst_err",   err,    1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_phase(input bit real_wb, input int n);
        for (int k = 0; k < n; k++) begin
            lock   = ($urandom_range(9) != 0);
            fe     = ($urandom_range(4) != 0);
            isctrl = ($urandom_range(7) == 0);
            gpu    = ($urandom_range(7) == 0);
            src1   = 4'($urandom_range(3));  src2   = 4'($urandom_range(3));
            vsrc1  = 6'($urandom_range(3));  vsrc2  = 6'($urandom_range(3));
            dest   = 4'($urandom_range(3));  vdest  = 6'($urandom_range(3));
            wbidx  = 4'($urandom_range(3));  wbvidx = 6'($urandom_range(3));
            use_   = 5'($urandom_range(31));
            dw     = 3'($urandom_range(7) & $urandom_range(7));
            wben   = 3'($urandom_range(7));
            if (real_wb) begin
                if (m_s[wbidx] == 0)  wben[0] = 1'b0;
                if (m_v[wbvidx] == 0) wben[1] = 1'b0;
                if (m_cc == 0)        wben[2] = 1'b0;
            end
            pcen = m_bw ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
            if (!real_wb && $urandom_range(199) == 0) apply_reset();
            cyc();
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_dep", dstall, 1'b0);
        check("reset_err", err, 1'b0);
        rst_n = 1'b1;
        cyc();
        check("post_reset_bs", got_bs, 1'b0);

        // ADD R3, then reader of R3
        idle(); fe = 1'b1; dw = 3'b001; dest = 4'd3;
        cyc(); check("add_r3_issue", got_iss, 1'b1);
        dw = '0; use_ = 5'b00001; src1 = 4'd3;
        cyc(); check("r3_dep", got_dep, 1'b1);
        wben = 3'b001; wbidx = 4'd3;
        cyc(); check("r3_wb_dep", got_dep, !BYP);
        wben = '0;
        cyc(); check("r3_clear_dep", got_dep, 1'b0); check("r3_clear_iss", got_iss, 1'b1);

        // two writes to R5, reader needs both writebacks
        idle(); fe = 1'b1; dw = 3'b001; dest = 4'd5;
        cyc(); cyc();
        dw = '0; use_ = 5'b00010; src2 = 4'd5; wben = 3'b001; wbidx = 4'd5;
        cyc(); check("r5_first_wb", got_dep, 1'b1);
        cyc(); check("r5_second_wb", got_dep, !BYP);
        wben = '0;
        cyc(); check("r5_clear", got_dep, 1'b0); check("r5_no_err", got_err, 1'b0);

        // R4: simultaneous issue-write and writeback keep the count at 1
        idle(); fe = 1'b1; dw = 3'b001; dest = 4'd4;
        cyc();
        wben = 3'b001; wbidx = 4'd4;
        cyc(); check("r4_same_cycle_iss", got_iss, 1'b1);
        wben = '0; dw = '0; use_ = 5'b00001; src1 = 4'd4;
        cyc(); check("r4_still_dep", got_dep, 1'b1);
        idle(); wben = 3'b001; wbidx = 4'd4;
        cyc();

        // BRZ on pending CC, then wait for PC writeback
        idle(); fe = 1'b1; dw = 3'b100;
        cyc();
        dw = '0; use_ = 5'b10000; isctrl = 1'b1;
        cyc(); check("brz_dep", got_dep, 1'b1); check("brz_bs", got_bs, 1'b1);
        wben = 3'b100;
        cyc();
        if (!BYP) begin wben = '0; cyc(); end
        check("brz_issue", got_iss, 1'b1);
        idle();
        cyc(); check("brwait_bs", got_bs, 1'b1);
        pcen = 1'b1;
        cyc(); check("pcen_bs", got_bs, 1'b1);
        pcen = 1'b0;
        cyc(); check("after_pcen_bs", got_bs, 1'b0);

        // LOCK low / GPU stall freeze issue; underflow is sticky
        idle(); fe = 1'b1; lock = 1'b0; dw = 3'b001; dest = 4'd6;
        cyc(); check("nolock_iss", got_iss, 1'b0);
        lock = 1'b1; gpu = 1'b1;
        cyc(); check("gpu_iss", got_iss, 1'b0);
        gpu = 1'b0; dw = '0; use_ = 5'b00001; src1 = 4'd6;
        cyc(); check("r6_frozen", got_dep, 1'b0);
        idle(); wben = 3'b001; wbidx = 4'd2;
        cyc(); check("uflow_pre", got_err, 1'b0);
        wben = '0;
        cyc(); check("uflow_err", got_err, 1'b1);
        cyc(); check("uflow_sticky", got_err, 1'b1);

        // reset while in BR_WAIT with V7 pending
        apply_reset();
        idle(); fe = 1'b1; dw = 3'b010; vdest = 6'd7;
        cyc();
        dw = '0; isctrl = 1'b1;
        cyc(); check("jmp_iss", got_iss, 1'b1);
        isctrl = 1'b0; use_ = 5'b00100; vsrc1 = 6'd7;
        cyc(); check("v7_bs", got_bs, 1'b1);
        apply_reset();
        idle(); fe = 1'b1; use_ = 5'b00100; vsrc1 = 6'd7;
        cyc(); check("v7_after_rst_iss", got_iss, 1'b1);

        apply_reset();
        idle();
        rand_phase(1'b1, 1500);
        apply_reset();
        rand_phase(1'b0, 1500);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
